// File: rtl/riscv_pkg.sv
// riscv_pkg -- constants shared by the pipeline control blocks
// (pipe_hazard_ctrl, hazard_detect, control_unit).
//   ST_*            : hazard-controller FSM state encoding
//   MC_LATENCY_DEF  : default EX occupancy of a CUSTOM0 multi-cycle op
//   OPC_/F3_/F7_    : CUSTOM0 opcode and funct fields decoded by control_unit
//   is_x0()         : true when a register address names the hard-wired zero
package riscv_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_MC_WAIT  = 2'd2;

  localparam int unsigned MC_LATENCY_DEF = 3;

  localparam logic [6:0] OPC_CUSTOM0    = 7'b0001011;
  localparam logic [2:0] F3_MIN_U       = 3'b000;
  localparam logic [2:0] F3_ABS_DIFF_U  = 3'b001;
  localparam logic [6:0] F7_CUSTOM0     = 7'b0000000;

  function automatic logic is_x0(input logic [4:0] addr);
    return (addr == 5'd0);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect -- purely combinational load-use compare.
// Ports:
//   i_id_valid, i_id_rs1_addr, i_id_rs2_addr, i_id_uses_rs1, i_id_uses_rs2 : ID operand info
//   i_ex_valid, i_ex_mem_read_en, i_ex_rd_addr                              : EX load info
//   o_load_use : consumer in ID needs the result of the load currently in EX
module hazard_detect
  import riscv_pkg::*;
(
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1_addr,
  input  logic [4:0] i_id_rs2_addr,
  input  logic       i_id_uses_rs1,
  input  logic       i_id_uses_rs2,
  input  logic       i_ex_valid,
  input  logic       i_ex_mem_read_en,
  input  logic [4:0] i_ex_rd_addr,
  output logic       o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = i_id_uses_rs1 & (i_id_rs1_addr == i_ex_rd_addr);
  assign w_rs2_hit = i_id_uses_rs2 & (i_id_rs2_addr == i_ex_rd_addr);

  // x0 is never really written, so a load targeting it cannot create a hazard
  assign o_load_use = i_id_valid & i_ex_valid & i_ex_mem_read_en &
                      ~is_x0(i_ex_rd_addr) & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- pipeline stall/flush/bubble controller.
// Ports:
//   clk, rst (async, active-high)
//   id_*  : ID-stage operand usage;  ex_* : EX-stage load/redirect/multi-cycle info
//   mem_req, dmem_ready : data-memory handshake of the MEM stage
//   stall_*, flush_id, bubble_*, mc_done : Mealy control outputs (0 during rst)
//   stall_cycles, flush_count : saturating event counters
// Priority in RUN: memory wait > redirect > multi-cycle start > load-use.
module pipe_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned MC_LATENCY = MC_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_mem_read_en,
  input  logic        ex_redirect,
  input  logic        ex_mc_op,
  input  logic        mem_req,
  input  logic        dmem_ready,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_mem,
  output logic        flush_id,
  output logic        bubble_ex,
  output logic        bubble_mem,
  output logic        bubble_wb,
  output logic        mc_done,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  // The start cycle is EX cycle 1 and the done cycle is the last, so the
  // counter only has to cover the MC_LATENCY-2 cycles in between.
  localparam bit          MC_MULTI    = (MC_LATENCY > 1);
  localparam int unsigned MC_RELOAD_I = MC_MULTI ? (MC_LATENCY - 2) : 0;
  localparam logic [3:0]  MC_RELOAD   = MC_RELOAD_I[3:0];

  logic [1:0]  r_state;
  logic [3:0]  r_mc_cnt;
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  logic [1:0]  w_next_state;
  logic [3:0]  w_next_cnt;
  logic        w_load_use;
  logic        w_mem_wait;
  logic        w_stall_if, w_stall_id, w_stall_ex, w_stall_mem;
  logic        w_flush_id, w_bubble_ex, w_bubble_mem, w_bubble_wb, w_mc_done;

  hazard_detect u_hazard_detect (
    .i_id_valid       (id_valid),
    .i_id_rs1_addr    (id_rs1_addr),
    .i_id_rs2_addr    (id_rs2_addr),
    .i_id_uses_rs1    (id_uses_rs1),
    .i_id_uses_rs2    (id_uses_rs2),
    .i_ex_valid       (ex_valid),
    .i_ex_mem_read_en (ex_mem_read_en),
    .i_ex_rd_addr     (ex_rd_addr),
    .o_load_use       (w_load_use)
  );

  assign w_mem_wait = mem_req & ~dmem_ready;

  // Next-state and Mealy output decode
  always_comb begin
    w_next_state = ST_RUN;
    w_next_cnt   = 4'd0;
    w_stall_if   = 1'b0;
    w_stall_id   = 1'b0;
    w_stall_ex   = 1'b0;
    w_stall_mem  = 1'b0;
    w_flush_id   = 1'b0;
    w_bubble_ex  = 1'b0;
    w_bubble_mem = 1'b0;
    w_bubble_wb  = 1'b0;
    w_mc_done    = 1'b0;
    case (r_state)
      // MEM_WAIT decodes like RUN: once dmem_ready rises the lower-priority
      // events are taken in that same cycle and the FSM leaves on the next edge.
      ST_RUN, ST_MEM_WAIT: begin
        if (w_mem_wait) begin
          w_stall_if   = 1'b1;
          w_stall_id   = 1'b1;
          w_stall_ex   = 1'b1;
          w_stall_mem  = 1'b1;
          w_bubble_wb  = 1'b1;
          w_next_state = ST_MEM_WAIT;
        end else if (ex_valid & ex_redirect) begin
          // stall_ex is necessarily 0 here; load-use is dropped with the flush
          w_flush_id  = 1'b1;
          w_bubble_ex = 1'b1;
        end else if (ex_valid & ex_mc_op & MC_MULTI) begin
          w_stall_if   = 1'b1;
          w_stall_id   = 1'b1;
          w_stall_ex   = 1'b1;
          w_bubble_mem = 1'b1;
          w_next_cnt   = MC_RELOAD;
          w_next_state = ST_MC_WAIT;
        end else begin
          // only reachable with a live ex_mc_op when MC_LATENCY is 1
          w_mc_done   = ex_valid & ex_mc_op;
          w_stall_if  = w_load_use;
          w_stall_id  = w_load_use;
          w_bubble_ex = w_load_use;
        end
      end
      ST_MC_WAIT: begin
        if (r_mc_cnt != 4'd0) begin
          w_stall_if   = 1'b1;
          w_stall_id   = 1'b1;
          w_stall_ex   = 1'b1;
          w_bubble_mem = 1'b1;
          w_next_cnt   = r_mc_cnt - 4'd1;
          w_next_state = ST_MC_WAIT;
        end else begin
          w_mc_done   = 1'b1;
          w_stall_if  = w_load_use;
          w_stall_id  = w_load_use;
          w_bubble_ex = w_load_use;
        end
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase
  end

  // Outputs are forced low while rst is high
  assign stall_if     = w_stall_if   & ~rst;
  assign stall_id     = w_stall_id   & ~rst;
  assign stall_ex     = w_stall_ex   & ~rst;
  assign stall_mem    = w_stall_mem  & ~rst;
  assign flush_id     = w_flush_id   & ~rst;
  assign bubble_ex    = w_bubble_ex  & ~rst;
  assign bubble_mem   = w_bubble_mem & ~rst;
  assign bubble_wb    = w_bubble_wb  & ~rst;
  assign mc_done      = w_mc_done    & ~rst;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

  // FSM state and multi-cycle down-counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_mc_cnt <= 4'd0;
    end else begin
      r_state  <= w_next_state;
      r_mc_cnt <= w_next_cnt;
    end
  end

  // Saturating stall / flush event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 16'd0;
    end else begin
      if (w_stall_if && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_flush_id && (r_flush_count != 16'hFFFF)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

endmodule
